// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit accumulator CPU: 2**ADDR_W x DATA_W
// store behind valid/ready request and response channels, with wait states.
module cpu_mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_M1 =
    NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic accept;
  logic commit;
  logic c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rsp_we_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rsp_we_q <= rsp_we_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (req_valid) begin
          if (NO_WAIT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end
        end
      end
      state_q == S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      state_q == S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait states the commit edge is the accept edge itself,
  // so the transaction comes straight from the request port.
  always_comb begin
    accept  = (state_q == S_IDLE) && req_valid;
    commit  = (state_d == S_RESP) && (state_q != S_RESP);
    c_we    = (state_q == S_IDLE) ? req_we    : we_q;
    c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    we_d    = accept ? req_we    : we_q;
    addr_d  = accept ? req_addr  : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d  = rdata_q;
    rsp_we_d = rsp_we_q;
    mem_d    = mem_q;
    if (commit) begin
      rsp_we_d = c_we;
      rdata_d  = c_we ? c_wdata : mem_q[c_addr];
      if (c_we) begin
        mem_d[c_addr] = c_wdata;
      end
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    rsp_rdata = rdata_q;
    rsp_we    = rsp_we_q;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: three instances (0, 3 and 5 wait states)
// checked every cycle against a transaction-level model.
module tb_cpu_mem_responder;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N-1:0] req_we;
  logic [N-1:0][4:0] req_addr;
  logic [N-1:0][7:0] req_wdata;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready;
  logic [N-1:0][7:0] rsp_rdata;
  logic [N-1:0] rsp_we;
  logic [N-1:0] busy;

  always #5 clk = ~clk;

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    cpu_mem_responder #(
      .ADDR_W(5),
      .DATA_W(8),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_we(rsp_we[g]),
      .busy(busy[g])
    );
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(string nm);
    checks++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Transaction model: one outstanding transaction per instance, timed by
  // its accept cycle; the response is visible from accept + WAIT_STATES.
  int cyc = 0;
  bit [7:0] mm [N][32];
  bit pend [N];
  int acc [N];
  bit t_we [N];
  bit [4:0] t_a [N];
  bit [7:0] t_d [N];
  bit [7:0] e_rd [N];
  bit e_we [N];
  bit pre_v [N];

  function automatic bit m_valid(int k);
    return pend[k] && (cyc >= acc[k] + ws_of(k));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0;
      for (int k = 0; k < N; k++) begin
        pend[k] = 1'b0;
        e_rd[k] = 8'h00;
        e_we[k] = 1'b0;
        for (int a = 0; a < 32; a++) mm[k][a] = 8'h00;
      end
    end else begin
      for (int k = 0; k < N; k++) pre_v[k] = m_valid(k);
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          if (pre_v[k] && rsp_ready[k]) pend[k] = 1'b0;
        end else if (req_valid[k]) begin
          pend[k] = 1'b1;
          acc[k]  = cyc;
          t_we[k] = req_we[k];
          t_a[k]  = req_addr[k];
          t_d[k]  = req_wdata[k];
        end
        if (pend[k] && cyc == acc[k] + ws_of(k)) begin
          e_we[k] = t_we[k];
          e_rd[k] = t_we[k] ? t_d[k] : mm[k][t_a[k]];
          if (t_we[k]) mm[k][t_a[k]] = t_d[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("k%0d req_ready", k), 32'(req_ready[k]),
            32'(!pend[k]));
        chk($sformatf("k%0d rsp_valid", k), 32'(rsp_valid[k]),
            32'(m_valid(k)));
        chk($sformatf("k%0d busy", k), 32'(busy[k]), 32'(pend[k]));
        chk($sformatf("k%0d rsp_rdata", k), 32'(rsp_rdata[k]),
            32'(e_rd[k]));
        chk($sformatf("k%0d rsp_we", k), 32'(rsp_we[k]), 32'(e_we[k]));
      end
    end
  end

  task automatic do_txn(input int k, input bit we, input bit [4:0] a,
                        input bit [7:0] d, output int lat,
                        output int acc_c, output logic [7:0] rd,
                        output logic rw);
    int n;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    rsp_ready[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) tmo("accept");
    @(posedge clk);
    #1;
    acc_c = cyc;
    req_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[k] && lat < 50);
    if (lat >= 50) tmo("response");
    rd = rsp_rdata[k];
    rw = rsp_we[k];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ac, prev;
    logic [7:0] rd;
    logic rw;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    do_txn(0, 1'b0, 5'h1F, 8'h00, lat, ac, rd, rw);
    chk("rd1f lat", 32'(lat), 1);
    chk("rd1f data", 32'(rd), 32'h00);
    chk("rd1f we", 32'(rw), 0);

    do_txn(0, 1'b1, 5'h03, 8'hA5, lat, ac, rd, rw);
    chk("wr03 ack", 32'(rd), 32'hA5);
    chk("wr03 we", 32'(rw), 1);
    do_txn(0, 1'b0, 5'h03, 8'h00, lat, ac, rd, rw);
    chk("rd03", 32'(rd), 32'hA5);
    do_txn(0, 1'b0, 5'h04, 8'h00, lat, ac, rd, rw);
    chk("rd04", 32'(rd), 32'h00);
    do_txn(0, 1'b0, 5'h02, 8'h00, lat, ac, rd, rw);
    chk("rd02", 32'(rd), 32'h00);

    do_txn(1, 1'b1, 5'h03, 8'h5A, lat, ac, rd, rw);
    chk("ws3 wr lat", 32'(lat), 4);
    chk("ws3 wr ack", 32'(rd), 32'h5A);
    do_txn(1, 1'b0, 5'h03, 8'h00, lat, ac, rd, rw);
    chk("ws3 rd lat", 32'(lat), 4);
    chk("ws3 rd data", 32'(rd), 32'h5A);

    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 5'h03;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 5'h0C;
    req_wdata[0] = 8'h33;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", 32'(rsp_valid[0]), 1);
      chk("bp data", 32'(rsp_rdata[0]), 32'hA5);
      chk("bp ready", 32'(req_ready[0]), 0);
      @(posedge clk);
      #1;
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp release ready", 32'(req_ready[0]), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp idle ready", 32'(req_ready[0]), 1);
    chk("bp idle valid", 32'(rsp_valid[0]), 0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp new valid", 32'(rsp_valid[0]), 1);
    chk("bp new data", 32'(rsp_rdata[0]), 32'h33);
    chk("bp new we", 32'(rsp_we[0]), 1);
    @(posedge clk);
    #1;

    prev = 0;
    for (int a = 0; a < 32; a++) begin
      do_txn(0, 1'b1, 5'(a), 8'(a) ^ 8'hFF, lat, ac, rd, rw);
      if (a > 0) chk("b2b wr period", 32'(ac - prev), 2);
      prev = ac;
    end
    for (int a = 0; a < 32; a++) begin
      do_txn(0, 1'b0, 5'(a), 8'h00, lat, ac, rd, rw);
      chk("b2b rd period", 32'(ac - prev), 2);
      chk($sformatf("b2b rd %0d", a), 32'(rd), 32'(8'(a) ^ 8'hFF));
      prev = ac;
    end

    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 5'h10;
    req_wdata[2] = 8'h77;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid valid", 32'(rsp_valid[2]), 0);
      chk("mid busy", 32'(busy[2]), 1);
    end
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post rst ready", 32'(req_ready[2]), 1);
    chk("post rst valid", 32'(rsp_valid[2]), 0);
    do_txn(2, 1'b0, 5'h10, 8'h00, lat, ac, rd, rw);
    chk("post rst rd10", 32'(rd), 32'h00);
    chk("ws5 lat", 32'(lat), 6);
    do_txn(0, 1'b0, 5'h05, 8'h00, lat, ac, rd, rw);
    chk("post rst rd05", 32'(rd), 32'h00);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the 8-bit accumulator CPU's memory interface.
- Holds the 32 x 8 program/data store.
- Services single read or write requests from the CPU side (instruction fetch, LDA/ADD/AND/XOR operand read, STO write) over a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states so the CPU can be run against slow-memory timing.

Parameters:
- ADDR_W, 5, address width; memory depth = 2**ADDR_W words.
- DATA_W, 8, data word width.
- WAIT_STATES, 0, extra cycles between request accept and response; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data, ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response this cycle.
- rsp_rdata  output  DATA_W  read data, or the written data for a write ack.
- rsp_we  output  1  echo of req_we for the transaction being answered.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; req_ready=1 once rst releases.
  - rsp_valid=0, rsp_rdata=0, rsp_we=0, busy=0, wait counter=0.
  - All memory words cleared to 0x00 (opcode 000 = HLT, so an unloaded memory halts a fetching CPU).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready (accept), latch we/addr/wdata into internal registers.
  - If WAIT_STATES==0, go to RESP next cycle; otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each cycle; when counter==0, go to RESP.
- Commit point: on the clock edge that enters RESP.
  - Write: mem[addr]<=wdata and rsp_rdata<=wdata.
  - Read: rsp_rdata<=mem[addr] (value before any same-edge write; no write can be in flight, so reads always see all prior writes).
  - rsp_we<=latched we.
- RESP:
  - rsp_valid=1, req_ready=0; rsp_rdata and rsp_we held stable.
  - On rsp_ready=1, go to IDLE next cycle and drop rsp_valid.
  - While rsp_ready=0, stay and hold indefinitely.
- Latency and throughput:
  - Accept edge to rsp_valid high = WAIT_STATES+1 cycles.
  - Minimum transaction period = WAIT_STATES+2 cycles, because req_ready is low in RESP. No pipelining and no overlap.
- req_* inputs are ignored whenever req_ready=0. A request may be held valid across RESP; it is accepted in the next IDLE cycle.
- Address wrap: none needed, since all 2**ADDR_W addresses are valid.
- busy = (state != IDLE).
- Reset mid-operation:
  - Abandons the transaction; no response is produced.
  - A write still in WAIT is never committed.
  - Memory is cleared regardless.
- rsp_rdata holds its last value in IDLE/WAIT and is cleared only by reset.

Test Plan:
- Reset then read: read addr 0x1F, WAIT_STATES=0 -> rsp_valid high exactly 1 cycle after accept, rsp_rdata=0x00, rsp_we=0.
- Write/read-back: write 0xA5 to 0x03, then read 0x03 -> write ack rsp_rdata=0xA5, rsp_we=1; read returns 0xA5; other addresses remain 0x00.
- Wait states: WAIT_STATES=3, read 0x03 after writing 0x5A -> rsp_valid rises 4 cycles after accept; req_ready and rsp_valid are low for the 3 intervening cycles; busy high throughout.
- Backpressure: rsp_ready=0 for 5 cycles in RESP with req_valid held high on a new request -> rsp_valid and rsp_rdata held; new request not accepted until the cycle after rsp_ready=1.
- Back-to-back: 32 writes of data=addr^0xFF, then 32 reads, WAIT_STATES=0 -> each transaction takes exactly 2 cycles; all reads return addr^0xFF.
- Reset mid-write: WAIT_STATES=5, accept write 0x77 to 0x10, assert rst in the WAIT state -> no rsp_valid; after release, a read of 0x10 returns 0x00 and req_ready=1.
